// File: rtl/regbank_wb_scheduler_pkg.sv
// Shared constants and types for the register-bank writeback scheduler.
//   DataW / AddrW : register data and address widths (32 x 32-bit registers)
//   RegX0         : hard-wired zero register, never written
//   gnt_e         : which writeback source owns the register-bank write port
package regbank_wb_scheduler_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;

  localparam logic [AddrW-1:0] RegX0 = '0;

  typedef enum logic [1:0] {
    GntNone = 2'd0,
    GntWb0  = 2'd1,
    GntWb1  = 2'd2
  } gnt_e;

endpackage

// File: rtl/regbank_wb_scheduler_if.sv
// Bus bundle between the writeback scheduler and its neighbours.
//   wb0_*      : pipeline writeback (no ready; held by pipe_stall)
//   wb1_*      : long-latency result with valid/ready handshake
//   issue_*    : decode issuing a long-latency op (valid/ready)
//   rs1/rs2_*  : decode source operands and their busy flags
//   rd_addr, rd_data, write_ena : RegisterBank write port
// slave modport is the scheduler side, master is the environment side.
interface regbank_wb_scheduler_if
  import regbank_wb_scheduler_pkg::*;
#(
  parameter int unsigned DW = DataW,
  parameter int unsigned AW = AddrW
) ();

  logic          wb0_valid;
  logic [AW-1:0] wb0_addr;
  logic [DW-1:0] wb0_data;

  logic          wb1_valid;
  logic          wb1_ready;
  logic [AW-1:0] wb1_addr;
  logic [DW-1:0] wb1_data;

  logic          pipe_stall;

  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;

  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          rs1_busy;
  logic          rs2_busy;

  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          write_ena;

  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    output wb1_ready,
    output pipe_stall,
    input  issue_valid, issue_rd,
    output issue_ready,
    input  rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy,
    output rd_addr, rd_data, write_ena
  );

  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    input  wb1_ready,
    input  pipe_stall,
    output issue_valid, issue_rd,
    input  issue_ready,
    output rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy,
    input  rd_addr, rd_data, write_ena
  );

endinterface

// File: rtl/regbank_wb_scheduler_wb_scoreboard.sv
// Pending-result scoreboard for long-latency (wb1) destinations.
//   clk, rst      : clock, synchronous active-high reset
//   issue_valid   : decode issues a long-latency op to issue_rd
//   issue_ready   : issue accepted (slot free and issue_rd not already pending)
//   wb1_xfer      : a wb1 result is being written this cycle to wb1_addr
//   rs1/rs2_addr  : decode source operands
//   rs1/rs2_busy  : source has a pending wb1 result (never for x0)
module regbank_wb_scheduler_wb_scoreboard
  import regbank_wb_scheduler_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [AddrW-1:0] issue_rd,
  output logic             issue_ready,
  input  logic             wb1_xfer,
  input  logic [AddrW-1:0] wb1_addr,
  input  logic [AddrW-1:0] rs1_addr,
  input  logic [AddrW-1:0] rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy
);

  localparam int unsigned NumRegs = 2 ** AddrW;
  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [NumRegs-1:0] busy_q, busy_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               issue_xfer;

  // Uses the registered busy bit, so an issue to a register whose result is
  // landing this very cycle is still refused (no same-cycle bypass).
  assign issue_ready = !rst && (cnt_q < CntMax) &&
                       ((issue_rd == RegX0) || !busy_q[issue_rd]);
  assign issue_xfer  = issue_valid && issue_ready;

  assign rs1_busy = (rs1_addr != RegX0) && busy_q[rs1_addr];
  assign rs2_busy = (rs2_addr != RegX0) && busy_q[rs2_addr];

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (wb1_xfer) begin
      busy_d[wb1_addr] = 1'b0;
    end
    if (issue_xfer && (issue_rd != RegX0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    unique case ({issue_xfer, wb1_xfer})
      2'b10: cnt_d = cnt_q + CntW'(1);
      // A result with nothing outstanding is a protocol error; hold at zero.
      2'b01: if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/regbank_wb_scheduler.sv
// Owner of the single RegisterBank write port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : regbank_wb_scheduler_if.slave (wb0, wb1, issue, rs*, write port)
// Arbitrates pipeline writeback (wb0) against long-latency results (wb1),
// suppresses writes to x0, and raises a registered pipe_stall when wb1 has
// been refused for MaxWait consecutive cycles so wb1 is guaranteed progress.
module regbank_wb_scheduler
  import regbank_wb_scheduler_pkg::*;
#(
  parameter int unsigned MaxWait        = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input logic                    clk,
  input logic                    rst,
  regbank_wb_scheduler_if.slave  bus
);

  localparam int unsigned StarveW = $clog2(MaxWait) + 1;

  localparam logic [StarveW-1:0] StarveLast = StarveW'(MaxWait - 1);

  gnt_e               gnt;
  logic               wb1_xfer;
  logic               wb1_refused;
  logic               stall_set;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               stall_q, stall_d;

  // Grant: a pending stall hands the port to wb1, otherwise wb0 has priority.
  always_comb begin
    gnt = GntNone;
    if (rst) begin
      gnt = GntNone;
    end else if (stall_q) begin
      if (bus.wb1_valid) gnt = GntWb1;
    end else if (bus.wb0_valid) begin
      gnt = GntWb0;
    end else if (bus.wb1_valid) begin
      gnt = GntWb1;
    end
  end

  always_comb begin
    bus.rd_addr   = '0;
    bus.rd_data   = '0;
    bus.write_ena = 1'b0;
    unique case (gnt)
      GntWb0: begin
        bus.rd_addr   = bus.wb0_addr;
        bus.rd_data   = bus.wb0_data;
        bus.write_ena = (bus.wb0_addr != RegX0);
      end
      GntWb1: begin
        bus.rd_addr   = bus.wb1_addr;
        bus.rd_data   = bus.wb1_data;
        bus.write_ena = (bus.wb1_addr != RegX0);
      end
      default: ;
    endcase
  end

  // A grant to x0 still completes the handshake; only the write is dropped.
  assign bus.wb1_ready = bus.wb1_valid && (gnt == GntWb1);
  assign wb1_xfer      = bus.wb1_ready;
  assign wb1_refused   = bus.wb1_valid && !bus.wb1_ready;
  assign bus.pipe_stall = stall_q;

  assign stall_set = wb1_refused && (starve_q == StarveLast);

  always_comb begin
    starve_d = starve_q;
    if (!bus.wb1_valid || wb1_xfer) begin
      starve_d = '0;
    end else if (starve_q != StarveLast) begin
      starve_d = starve_q + StarveW'(1);
    end
    // Held until wb1 actually transfers, then drops the following cycle.
    stall_d = stall_set || (stall_q && !wb1_xfer);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  regbank_wb_scheduler_wb_scoreboard #(
    .MaxOutstanding (MaxOutstanding)
  ) u_wb_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .issue_ready (bus.issue_ready),
    .wb1_xfer    (wb1_xfer),
    .wb1_addr    (bus.wb1_addr),
    .rs1_addr    (bus.rs1_addr),
    .rs2_addr    (bus.rs2_addr),
    .rs1_busy    (bus.rs1_busy),
    .rs2_busy    (bus.rs2_busy)
  );

endmodule

// File: tb/tb_regbank_wb_scheduler.sv
// Directed bench: stimulus pushes expected register-bank writes into a queue,
// a negedge monitor pops and compares whenever write_ena is seen.
module tb_regbank_wb_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regbank_wb_scheduler_if bus ();

  regbank_wb_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] bank[32];

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = '0;
  end

  // Stand-in RegisterBank: commits whatever the scheduler presents.
  always @(posedge clk) begin
    if (bus.write_ena) bank[bus.rd_addr] <= bus.rd_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.write_ena === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=x%0d:%0h expected=none", bus.rd_addr, bus.rd_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(bus.rd_addr), 32'(e.addr));
        check("write_data", bus.rd_data, e.data);
      end
    end
  end

  task automatic clear_inputs();
    bus.wb0_valid   = 1'b0;
    bus.wb0_addr    = '0;
    bus.wb0_data    = '0;
    bus.wb1_valid   = 1'b0;
    bus.wb1_addr    = '0;
    bus.wb1_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1_addr    = '0;
    bus.rs2_addr    = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] drain[4];
    drain = '{5'd7, 5'd9, 5'd10, 5'd11};

    // Reset with traffic present: nothing may be granted or issued.
    rst = 1'b1;
    clear_inputs();
    bus.wb1_valid   = 1'b1;
    bus.wb1_addr    = 5'd4;
    bus.wb1_data    = 32'hDEAD_BEEF;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd6;
    cyc();
    #3;
    check("rst_write_ena", 32'(bus.write_ena), 32'd0);
    check("rst_wb1_ready", 32'(bus.wb1_ready), 32'd0);
    check("rst_issue_ready", 32'(bus.issue_ready), 32'd0);
    cyc();
    rst = 1'b0;
    clear_inputs();
    bus.rs1_addr = 5'd6;
    #3;
    check("post_rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
    check("post_rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);

    // wb0 to x5 goes straight to the port.
    cyc();
    bus.wb0_valid = 1'b1;
    bus.wb0_addr  = 5'd5;
    bus.wb0_data  = 32'hA5A5_A5A5;
    push(5'd5, 32'hA5A5_A5A5);
    #3;
    check("wb0_write_ena", 32'(bus.write_ena), 32'd1);
    check("wb0_rd_addr", 32'(bus.rd_addr), 32'd5);
    check("wb0_rd_data", bus.rd_data, 32'hA5A5_A5A5);
    cyc();
    clear_inputs();
    #3;
    check("bank_x5", bank[5], 32'hA5A5_A5A5);

    // wb0 to x0 must not write.
    cyc();
    bus.wb0_valid = 1'b1;
    bus.wb0_addr  = 5'd0;
    bus.wb0_data  = 32'hFFFF_FFFF;
    #3;
    check("x0_write_ena", 32'(bus.write_ena), 32'd0);
    cyc();
    clear_inputs();
    #3;
    check("bank_x0", bank[0], 32'd0);

    // Starvation: wb1 refused 4 cycles, forced through in cycle 5.
    cyc();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd2;
    #3;
    check("issue_x2_ready", 32'(bus.issue_ready), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      bus.issue_valid = 1'b0;
      bus.wb0_valid   = 1'b1;
      bus.wb0_addr    = 5'd1;
      bus.wb0_data    = 32'h1111_0000 + 32'(i);
      bus.wb1_valid   = 1'b1;
      bus.wb1_addr    = 5'd2;
      bus.wb1_data    = 32'h2222_2222;
      bus.rs1_addr    = 5'd2;
      push(5'd1, 32'h1111_0000 + 32'(i));
      #3;
      check("starve_wb1_ready", 32'(bus.wb1_ready), 32'd0);
      check("starve_pipe_stall", 32'(bus.pipe_stall), 32'd0);
      check("starve_rs1_busy", 32'(bus.rs1_busy), 32'd1);
    end
    cyc();
    bus.wb0_data = 32'h1111_0005;
    push(5'd2, 32'h2222_2222);
    #3;
    check("stall_pipe_stall", 32'(bus.pipe_stall), 32'd1);
    check("stall_wb1_ready", 32'(bus.wb1_ready), 32'd1);
    cyc();
    bus.wb1_valid = 1'b0;
    push(5'd1, 32'h1111_0005);
    #3;
    check("unstall_pipe_stall", 32'(bus.pipe_stall), 32'd0);
    check("unstall_rs1_busy", 32'(bus.rs1_busy), 32'd0);
    cyc();
    clear_inputs();

    // Fill the scoreboard, then free one slot.
    for (int i = 7; i <= 10; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'(i);
      #3;
      check("fill_issue_ready", 32'(bus.issue_ready), 32'd1);
      cyc();
    end
    bus.issue_rd = 5'd11;
    #3;
    check("full_issue_ready", 32'(bus.issue_ready), 32'd0);
    cyc();
    bus.wb1_valid = 1'b1;
    bus.wb1_addr  = 5'd8;
    bus.wb1_data  = 32'h8888_8888;
    push(5'd8, 32'h8888_8888);
    #3;
    check("full_clr_issue_ready", 32'(bus.issue_ready), 32'd0);
    check("x8_wb1_ready", 32'(bus.wb1_ready), 32'd1);
    cyc();
    bus.wb1_valid = 1'b0;
    bus.rs1_addr  = 5'd8;
    bus.rs2_addr  = 5'd9;
    #3;
    check("x8_rs1_busy", 32'(bus.rs1_busy), 32'd0);
    check("x9_rs2_busy", 32'(bus.rs2_busy), 32'd1);
    check("x11_issue_ready", 32'(bus.issue_ready), 32'd1);
    cyc();
    bus.issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wb1_valid = 1'b1;
      bus.wb1_addr  = drain[i];
      bus.wb1_data  = 32'h0101_0101 * 32'(drain[i]);
      push(drain[i], 32'h0101_0101 * 32'(drain[i]));
      #3;
      check("drain_wb1_ready", 32'(bus.wb1_ready), 32'd1);
      cyc();
    end
    clear_inputs();

    // WAW: a pending rd blocks re-issue, even in the cycle it clears.
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    #3;
    check("x3_first_issue", 32'(bus.issue_ready), 32'd1);
    cyc();
    #3;
    check("x3_reissue_a", 32'(bus.issue_ready), 32'd0);
    cyc();
    #3;
    check("x3_reissue_b", 32'(bus.issue_ready), 32'd0);
    cyc();
    bus.wb1_valid = 1'b1;
    bus.wb1_addr  = 5'd3;
    bus.wb1_data  = 32'h3333_3333;
    push(5'd3, 32'h3333_3333);
    #3;
    check("x3_same_cycle_clear", 32'(bus.issue_ready), 32'd0);
    cyc();
    bus.wb1_valid = 1'b0;
    #3;
    check("x3_after_clear", 32'(bus.issue_ready), 32'd1);
    cyc();
    bus.issue_rd = 5'd12;
    #3;
    check("x12_issue", 32'(bus.issue_ready), 32'd1);
    cyc();
    bus.issue_rd = 5'd13;
    #3;
    check("x13_issue", 32'(bus.issue_ready), 32'd1);

    // cnt=3 now; build a stall, then reset on top of it.
    for (int i = 1; i <= 4; i++) begin
      cyc();
      bus.issue_valid = 1'b0;
      bus.wb0_valid   = 1'b1;
      bus.wb0_addr    = 5'd1;
      bus.wb0_data    = 32'h4444_0000 + 32'(i);
      bus.wb1_valid   = 1'b1;
      bus.wb1_addr    = 5'd12;
      bus.wb1_data    = 32'hCCCC_CCCC;
      push(5'd1, 32'h4444_0000 + 32'(i));
      #3;
      check("rst_starve_wb1_ready", 32'(bus.wb1_ready), 32'd0);
    end
    cyc();
    rst = 1'b1;
    #3;
    check("rst_hold_pipe_stall", 32'(bus.pipe_stall), 32'd1);
    check("rst_hold_write_ena", 32'(bus.write_ena), 32'd0);
    check("rst_hold_wb1_ready", 32'(bus.wb1_ready), 32'd0);
    cyc();
    rst = 1'b0;
    clear_inputs();
    bus.rs1_addr = 5'd3;
    bus.rs2_addr = 5'd12;
    #3;
    check("after_rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
    check("after_rst_x3_busy", 32'(bus.rs1_busy), 32'd0);
    check("after_rst_x12_busy", 32'(bus.rs2_busy), 32'd0);
    cyc();
    for (int i = 20; i <= 23; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'(i);
      #3;
      check("after_rst_issue", 32'(bus.issue_ready), 32'd1);
      cyc();
    end
    bus.issue_rd = 5'd24;
    #3;
    check("after_rst_full", 32'(bus.issue_ready), 32'd0);
    cyc();
    clear_inputs();
    #3;
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
